mem_block_mover: RTL and testbench
==================================

// Module: mem_block_mover
// PURPOSE
//   Bus initiator for data_memory: drives Mem_read/Mem_write/address/write_data and consumes read_data.
//   Executes block commands: COPY (read src+k, write dst+k) or FILL (write fill_value to dst+k) for LEN words.
//   Accumulates a wrapping checksum of the words written. Sits between the control FSM/testbench and data_memory.
// PARAMETERS
//   ADDR_W  8  address width; all address arithmetic is modulo 2**ADDR_W
//   DATA_W  8  data word width
//   LEN_W   9  width of len; allows 0..256 words
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous, active-high reset
//   start       in   1       command strobe; sampled only in IDLE
//   mode        in   1       0 = COPY, 1 = FILL
//   src_addr    in   ADDR_W  COPY source base
//   dst_addr    in   ADDR_W  destination base
//   len         in   LEN_W   word count
//   fill_value  in   DATA_W  FILL data
//   Mem_read    out  1       memory read strobe
//   Mem_write   out  1       memory write strobe
//   address     out  ADDR_W  memory address
//   write_data  out  DATA_W  memory write data
//   read_data   in   DATA_W  registered memory read data; valid the cycle after a Mem_read cycle
//   busy        out  1       high in READ/WRITE/FILLW
//   done        out  1       one-cycle completion pulse
//   checksum    out  DATA_W  sum of written words mod 2**DATA_W; held until the next accepted start
//   words_done  out  LEN_W   words written in the current or last command
// BEHAVIOUR
//   Reset (sync): state=IDLE; Mem_read=Mem_write=0; address=0; write_data=0; busy=done=0; checksum=0; words_done=0.
//   States: IDLE, READ, WRITE, FILLW, FIN.
//   - Strobes, address and write_data are decoded from state and registered counters only. In IDLE/FIN they are all 0.
//   IDLE: start=1 at edge E0 latches src, dst, len, mode and fill_value; clears checksum, words_done and k.
//     - len==0: go to FIN; no memory access.
//     - Otherwise go to READ (COPY) or FILLW (FILL).
//   READ: Mem_read=1, address=src+k -> WRITE. The memory captures MEMO[src+k] at this edge.
//   WRITE: Mem_write=1, address=dst+k, write_data=read_data.
//     - At the edge: checksum+=read_data; words_done+=1; k+=1.
//     - Next state: FIN if k+1==len, else READ.
//   FILLW: Mem_write=1, address=dst+k, write_data=fill_value.
//     - Same counter updates as WRITE; stays in FILLW until k+1==len, then FIN.
//   FIN: done=1 for exactly one cycle -> IDLE.
//   Latency after edge E0:
//     - COPY: 2*len busy cycles, then the done cycle.
//     - FILL: len busy cycles, then done.
//     - len==0: done in the first cycle.
//   Never asserts Mem_read and Mem_write in the same cycle.
//   start while not in IDLE (including FIN) is ignored; the command inputs may change freely while busy.
//   Address wrap: src+k and dst+k wrap 255->0. len=256 touches every location once.
//   Overlap: the copy is strictly forward, word by word. A read at src+k is ordered after any earlier write to that address.
//   Reset mid-command: at that edge return to IDLE; strobes are low the next cycle; no done pulse; the partial writes stand.
// TESTING
//   1. Memory at reset values (MEMO[i]=i for i<16). COPY src=0 dst=64 len=16:
//      -> MEMO[64..79]=0..15, checksum=0x78, words_done=16, done in cycle 33.
//   2. COPY src=17 dst=100 len=3 -> MEMO[100..102]=FF,FE,FD; checksum=0xFA; the 6 strobe cycles alternate R,W.
//   3. FILL dst=250 len=10 fill=0xA5 -> MEMO[250..255] and MEMO[0..3]=A5; checksum=0x72; done in cycle 11.
//   4. len=0 -> done in cycle 1; no Mem_read/Mem_write ever high; checksum=0.
//   5. start pulsed again mid-COPY with other operands -> ignored; only the first command's writes occur.
//   6. reset at cycle 5 of a len=8 COPY -> strobes low the next cycle, no done, words_done=0; a new start works normally.

Source files
------------

// File: rtl/mem_block_mover_if.sv
// Memory bus between the block mover (initiator) and data_memory (target).
interface mem_block_mover_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              Mem_read;
  logic              Mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    output Mem_read,
    output Mem_write,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  Mem_read,
    input  Mem_write,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block COPY/FILL engine driving data_memory; accumulates a wrapping checksum of written words.
module mem_block_mover #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  mem_block_mover_if.master mem,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [LEN_W-1:0]  words_done
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StFillW, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  // cnt_q is both the word index k and the words-written count.
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  logic [LEN_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] offs;

  assign cnt_inc = cnt_q + LEN_W'(1);
  // Address arithmetic wraps modulo 2**ADDR_W.
  assign offs    = ADDR_W'(cnt_q);

  // Next-state: command latch, word counter and checksum accumulation.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = len;
          fill_d = fill_value;
          cnt_d  = '0;
          sum_d  = '0;
          if (len == '0) begin
            state_d = StFin;
          end else if (mode) begin
            state_d = StFillW;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        state_d = StWrite;
      end
      StWrite: begin
        sum_d   = sum_q + mem.read_data;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? StFin : StRead;
      end
      StFillW: begin
        sum_d   = sum_q + fill_q;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? StFin : StFillW;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus strobes and status decoded from state and registered counters only.
  always_comb begin
    mem.Mem_read   = 1'b0;
    mem.Mem_write  = 1'b0;
    mem.address    = '0;
    mem.write_data = '0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      StRead: begin
        busy         = 1'b1;
        mem.Mem_read = 1'b1;
        mem.address  = src_q + offs;
      end
      StWrite: begin
        busy           = 1'b1;
        mem.Mem_write  = 1'b1;
        mem.address    = dst_q + offs;
        mem.write_data = mem.read_data;
      end
      StFillW: begin
        busy           = 1'b1;
        mem.Mem_write  = 1'b1;
        mem.address    = dst_q + offs;
        mem.write_data = fill_q;
      end
      StFin: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign checksum   = sum_q;
  assign words_done = cnt_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: command table plus hand sequences, write scoreboard, memory model.
module tb_mem_block_mover;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] fill_value;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [LW-1:0] words_done;

  mem_block_mover_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_block_mover #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .mem        (mif),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return (i < 16) ? 8'(i) : 8'(272 - i);
  endfunction

  // data_memory model: registered read, write on strobe; loads its initial image on the first edge.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_q = '0;
  logic          mem_loaded = 1'b0;
  assign mif.read_data = rd_q;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mif.Mem_write) mem[mif.address] <= mif.write_data;
      if (mif.Mem_read) rd_q <= mem[mif.address];
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] len;
    logic [7:0] fill;
    int         sum;
    logic [8:0] words;
    int         done_cyc;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] ref_mem [256];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Advance to the next falling edge and score any write on the bus.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (mif.Mem_write === 1'b1) begin
      check("rw_exclusive", 32'(mif.Mem_read & mif.Mem_write), 0);
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mif.address), 32'(e.addr));
        check("write_data", 32'(mif.write_data), 32'(e.data));
        ref_mem[e.addr] = e.data;
      end
    end
  endtask

  // Forward word-by-word reference of the command; queues expected writes.
  task automatic plan(input logic m, input logic [7:0] s, input logic [7:0] d,
                      input logic [8:0] n, input logic [7:0] f, output logic [7:0] sum);
    logic [7:0] scratch [256];
    logic [7:0] data;
    scratch = ref_mem;
    sum = '0;
    for (int k = 0; k < int'(n); k++) begin
      data = m ? f : scratch[8'(int'(s) + k)];
      scratch[8'(int'(d) + k)] = data;
      exp_q.push_back('{addr: 8'(int'(d) + k), data: data});
      sum = sum + data;
    end
  endtask

  task automatic scramble();
    mode       = 1'($urandom);
    src_addr   = 8'($urandom);
    dst_addr   = 8'($urandom);
    len        = 9'($urandom);
    fill_value = 8'($urandom);
  endtask

  // exp_sum < 0 selects the reference-model checksum; poke re-strobes start at that cycle.
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] n, input logic [7:0] f, input int exp_sum,
                         input logic [8:0] exp_words, input int exp_done, input int poke);
    logic [7:0] msum;
    logic [7:0] want_sum;
    logic       exp_rd;
    logic       exp_wr;
    int         strobe_bad;
    int         c;
    plan(m, s, d, n, f, msum);
    want_sum   = (exp_sum < 0) ? msum : 8'(exp_sum);
    mode       = m;
    src_addr   = s;
    dst_addr   = d;
    len        = n;
    fill_value = f;
    start      = 1'b1;
    strobe_bad = 0;
    for (c = 1; c <= 600; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) scramble();
      if (c == poke) begin
        start = 1'b1;
        scramble();
      end
      if (done === 1'b1) break;
      exp_rd = !m && (c % 2 == 1);
      exp_wr = m || (c % 2 == 0);
      if (mif.Mem_read !== exp_rd || mif.Mem_write !== exp_wr || busy !== 1'b1) strobe_bad++;
    end
    check("done_cycle", 32'(c), 32'(exp_done));
    check("done_quiet", 32'({busy, mif.Mem_read, mif.Mem_write}), 0);
    check("checksum", 32'(checksum), 32'(want_sum));
    check("words_done", 32'(words_done), 32'(exp_words));
    check("strobe_pattern", 32'(strobe_bad), 0);
    tick();
    start = 1'b0;
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    check("writes_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    vec_t       vecs [7];
    logic [7:0] tmp_sum;
    int         diffs;
    int         no_done;

    vecs[0] = '{1'b0, 8'd0,   8'd64,  9'd16,  8'h00, 32'h78, 9'd16,  33};
    vecs[1] = '{1'b0, 8'd17,  8'd100, 9'd3,   8'h00, 32'hFA, 9'd3,   7};
    vecs[2] = '{1'b1, 8'd0,   8'd250, 9'd10,  8'hA5, 32'h72, 9'd10,  11};
    vecs[3] = '{1'b0, 8'd5,   8'd9,   9'd0,   8'h00, 32'h00, 9'd0,   1};
    vecs[4] = '{1'b1, 8'd0,   8'd40,  9'd0,   8'h3C, 32'h00, 9'd0,   1};
    vecs[5] = '{1'b0, 8'd64,  8'd65,  9'd4,   8'h00, 32'h00, 9'd4,   9};
    vecs[6] = '{1'b1, 8'd0,   8'd7,   9'd256, 8'h03, 32'h00, 9'd256, 257};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    reset      = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    len        = '0;
    fill_value = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_strobes", 32'({mif.Mem_read, mif.Mem_write}), 0);
    check("rst_address", 32'(mif.address), 0);
    check("rst_write_data", 32'(mif.write_data), 0);
    check("rst_checksum", 32'(checksum), 0);
    check("rst_words_done", 32'(words_done), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill,
              vecs[i].sum, vecs[i].words, vecs[i].done_cyc, 0);
    end

    // start re-strobed mid-COPY, then during the done cycle: both ignored.
    run_cmd(1'b0, 8'd0, 8'd128, 9'd4, 8'h00, -1, 9'd4, 9, 3);
    run_cmd(1'b1, 8'd0, 8'd20, 9'd3, 8'h5A, 32'h0E, 9'd3, 4, 4);

    // Reset at cycle 5 of an 8-word COPY.
    plan(1'b0, 8'd32, 8'd160, 9'd8, 8'h00, tmp_sum);
    mode     = 1'b0;
    src_addr = 8'd32;
    dst_addr = 8'd160;
    len      = 9'd8;
    start    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    check("mid_rst_strobes", 32'({mif.Mem_read, mif.Mem_write}), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_words", 32'(words_done), 0);
    check("mid_rst_partial", 32'(8 - exp_q.size()), 2);
    exp_q.delete();
    reset   = 1'b0;
    no_done = 0;
    repeat (6) begin
      tick();
      if (done !== 1'b0) no_done++;
    end
    check("no_done_after_rst", 32'(no_done), 0);
    run_cmd(1'b0, 8'd160, 8'd96, 9'd4, 8'h00, -1, 9'd4, 9, 0);

    repeat (2) tick();
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("memory_image", 32'(diffs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
